// File: rtl/clock_meas_pkg.sv
// Shared definitions for the clock period meter and its helpers.
//   meas_state_t        : measurement FSM states
//   DEFAULT_SYNC_STAGES : default depth of the input synchronizer
//   DEFAULT_CNT_WIDTH   : default width of the period/high counters
//   cnt_max()           : largest value a counter of the given width can hold
package clock_meas_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } meas_state_t;

  localparam int DEFAULT_SYNC_STAGES = 2;
  localparam int DEFAULT_CNT_WIDTH   = 16;

  function automatic longint unsigned cnt_max(input int unsigned width);
    return (64'd1 << width) - 64'd1;
  endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Synchronizes an asynchronous input into the clk domain and flags its
// rising edges.
//   clk      : system clock, rising edge
//   rst      : asynchronous, active-high reset
//   async_in : input asynchronous to clk
//   level    : synchronized copy of async_in (SYNC_STAGES flops deep)
//   rise     : high for one cycle when level goes 0 -> 1
// SYNC_STAGES must be at least 2.
module sync_rise_detect
  import clock_meas_pkg::*;
#(
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic level,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], async_in};
      level_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign rise  = level & ~level_d;

endmodule

// File: rtl/clock_period_meter.sv
// Measures period and high time of a clock-like signal in clk cycles.
//   clk       : system clock, rising edge
//   rst       : asynchronous, active-high reset
//   enable    : 1 = measure, 0 = idle
//   sig_in    : signal under measurement (asynchronous to clk)
//   period    : last measured period in clk cycles
//   high_time : last measured high time in clk cycles
//   valid     : one-cycle pulse when period/high_time update
//   timeout   : level, no rising edge seen within the counter range
//   busy      : 1 while in ARM or MEASURE
// valid is a plain strobe with no backpressure: period/high_time are stable
// from the cycle valid pulses until the next pulse.
module clock_period_meter
  import clock_meas_pkg::*;
#(
  parameter int CNT_WIDTH   = DEFAULT_CNT_WIDTH,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 sig_in,
  output logic [CNT_WIDTH-1:0] period,
  output logic [CNT_WIDTH-1:0] high_time,
  output logic                 valid,
  output logic                 timeout,
  output logic                 busy
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(cnt_max(CNT_WIDTH));
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic s;
  logic rise;

  sync_rise_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk     (clk),
    .rst     (rst),
    .async_in(sig_in),
    .level   (s),
    .rise    (rise)
  );

  meas_state_t          state, state_n;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [CNT_WIDTH-1:0] hcnt, hcnt_n;
  logic [CNT_WIDTH-1:0] period_n, high_time_n;
  logic                 valid_n, timeout_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      hcnt      <= '0;
      period    <= '0;
      high_time <= '0;
      valid     <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      hcnt      <= hcnt_n;
      period    <= period_n;
      high_time <= high_time_n;
      valid     <= valid_n;
      timeout   <= timeout_n;
    end
  end

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    hcnt_n      = hcnt;
    period_n    = period;
    high_time_n = high_time;
    valid_n     = 1'b0;
    timeout_n   = timeout;

    // Dropping enable wins over everything, including a coincident rise.
    if (!enable) begin
      state_n   = IDLE;
      cnt_n     = '0;
      hcnt_n    = '0;
      timeout_n = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          state_n = ARM;
          cnt_n   = '0;
          hcnt_n  = '0;
        end
        ARM: begin
          // The rise cycle is itself high and is the first cycle of the window.
          if (rise) begin
            state_n = MEASURE;
            cnt_n   = CNT_ONE;
            hcnt_n  = CNT_ONE;
          end
        end
        MEASURE: begin
          if (rise) begin
            period_n    = cnt;
            high_time_n = hcnt;
            valid_n     = 1'b1;
            timeout_n   = 1'b0;
            cnt_n       = CNT_ONE;
            hcnt_n      = CNT_ONE;
          end else if (cnt == CNT_MAX) begin
            // Counter full with no edge: give up on this window and rearm.
            // hcnt never exceeds cnt, so it cannot overflow either.
            state_n   = ARM;
            timeout_n = 1'b1;
          end else begin
            cnt_n  = cnt + CNT_ONE;
            hcnt_n = hcnt + {{(CNT_WIDTH-1){1'b0}}, s};
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_clock_period_meter.sv
// Self-checking bench for clock_period_meter (CNT_WIDTH = 8).
module tb_clock_period_meter;

  localparam int CW   = 8;
  localparam int MAXC = 255;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          enable = 1'b0;
  logic          sig_in = 1'b0;
  logic [CW-1:0] period;
  logic [CW-1:0] high_time;
  logic          valid;
  logic          timeout;
  logic          busy;

  int checks = 0;
  int errors = 0;
  int valid_seen = 0;

  clock_period_meter #(
    .CNT_WIDTH  (CW),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .enable   (enable),
    .sig_in   (sig_in),
    .period   (period),
    .high_time(high_time),
    .valid    (valid),
    .timeout  (timeout),
    .busy     (busy)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Works from timestamps of synchronized samples: the value sampled at an
  // edge becomes visible to the meter two edges later (two synchronizer
  // flops), and a rise is a 0 -> 1 step in that delayed stream. A window is
  // the list of synchronized samples since the last counted rise.
  int d0, d1, d2;
  int mode;            // 0 idle, 1 waiting for first rise, 2 measuring
  int win_q[$];
  int m_period, m_high, m_valid, m_timeout;
  int s_cur, r_cur, sum;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      d0 = 0; d1 = 0; d2 = 0;
      mode = 0;
      win_q.delete();
      m_period = 0; m_high = 0; m_valid = 0; m_timeout = 0;
    end else begin
      s_cur = d1;
      r_cur = (d1 == 1 && d2 == 0) ? 1 : 0;
      m_valid = 0;
      if (!enable) begin
        mode = 0;
        m_timeout = 0;
        win_q.delete();
      end else if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (r_cur == 1) begin
          win_q.delete();
          win_q.push_back(1);
          mode = 2;
        end
      end else begin
        if (r_cur == 1) begin
          sum = 0;
          foreach (win_q[i]) sum += win_q[i];
          m_period  = win_q.size();
          m_high    = sum;
          m_valid   = 1;
          m_timeout = 0;
          win_q.delete();
          win_q.push_back(1);
        end else if (win_q.size() == MAXC) begin
          m_timeout = 1;
          mode = 1;
        end else begin
          win_q.push_back(s_cur);
        end
      end
      d2 = d1;
      d1 = d0;
      d0 = int'(sig_in);
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    check("cyc_period",    32'(period),    32'(m_period));
    check("cyc_high_time", 32'(high_time), 32'(m_high));
    check("cyc_valid",     32'(valid),     32'(m_valid));
    check("cyc_timeout",   32'(timeout),   32'(m_timeout));
    check("cyc_busy",      32'(busy),      (mode != 0) ? 32'd1 : 32'd0);
    if (valid === 1'b1) valid_seen++;
  end

  // ---------------- driver tasks ----------------
  // All tasks start and end 2 time units after a rising edge.
  task automatic set_sig(input logic v, input int n);
    sig_in = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic run_wave(input int p, input int h, input int n);
    for (int i = 0; i < n; i++) begin
      sig_in = ((i % p) < h);
      @(posedge clk);
      #2;
    end
  endtask

  // ---------------- stimulus ----------------
  int vs;
  int p, h;

  initial begin
    // reset
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    check("rst_period", 32'(period), 0);
    check("rst_high", 32'(high_time), 0);
    check("rst_valid", 32'(valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_busy", 32'(busy), 0);
    @(posedge clk);
    #2;

    // period 10 / high 5, first-valid latency
    enable = 1'b1;
    set_sig(1'b0, 4);
    set_sig(1'b1, 5);
    set_sig(1'b0, 5);
    sig_in = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("lat_valid_early", 32'(valid), 0);
    @(posedge clk);
    @(negedge clk);
    check("lat_valid", 32'(valid), 1);
    check("lat_period", 32'(period), 10);
    check("lat_high", 32'(high_time), 5);
    @(posedge clk);
    #2;
    set_sig(1'b1, 1);
    set_sig(1'b0, 5);
    vs = valid_seen;
    run_wave(10, 5, 50);
    check("p10_pulses", 32'(valid_seen - vs), 5);
    check("p10_timeout", 32'(timeout), 0);
    check("p10_busy", 32'(busy), 1);

    // period 8 / high 3, then 12 / 9
    run_wave(8, 3, 64);
    check("p8_period", 32'(period), 8);
    check("p8_high", 32'(high_time), 3);
    run_wave(12, 9, 72);
    check("p12_period", 32'(period), 12);
    check("p12_high", 32'(high_time), 9);

    // fastest signal: toggling every clk
    run_wave(2, 1, 10);
    vs = valid_seen;
    run_wave(2, 1, 30);
    check("p2_pulses", 32'(valid_seen - vs), 15);
    check("p2_period", 32'(period), 2);
    check("p2_high", 32'(high_time), 1);

    // stuck low after one rise -> timeout
    set_sig(1'b1, 1);
    sig_in = 1'b0;
    repeat (255) @(posedge clk);
    @(negedge clk);
    check("to_not_yet", 32'(timeout), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("to_set", 32'(timeout), 1);
    check("to_period_hold", 32'(period), 2);
    check("to_high_hold", 32'(high_time), 1);
    @(posedge clk);
    #2;
    set_sig(1'b0, 5);
    run_wave(10, 5, 40);
    check("to_clear", 32'(timeout), 0);
    check("to_restart_period", 32'(period), 10);
    check("to_restart_high", 32'(high_time), 5);

    // asynchronous reset mid-period
    run_wave(10, 5, 23);
    #1;
    rst = 1'b1;
    #1;
    check("mid_rst_period", 32'(period), 0);
    check("mid_rst_high", 32'(high_time), 0);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_timeout", 32'(timeout), 0);
    check("mid_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #4;
    rst = 1'b0;
    @(posedge clk);
    #2;
    set_sig(1'b0, 3);
    run_wave(10, 5, 50);
    check("post_rst_period", 32'(period), 10);
    check("post_rst_high", 32'(high_time), 5);

    // enable dropped for 3 cycles across a rise
    run_wave(10, 5, 30);
    sig_in = 1'b1;
    @(posedge clk);
    #2;
    enable = 1'b0;
    vs = valid_seen;
    set_sig(1'b1, 3);
    check("en_no_valid", 32'(valid_seen - vs), 0);
    check("en_busy", 32'(busy), 0);
    check("en_timeout", 32'(timeout), 0);
    check("en_period_hold", 32'(period), 10);
    check("en_high_hold", 32'(high_time), 5);
    enable = 1'b1;
    set_sig(1'b1, 1);
    set_sig(1'b0, 5);
    run_wave(10, 5, 50);
    check("en_again_period", 32'(period), 10);
    check("en_again_high", 32'(high_time), 5);

    // randomized waveforms with occasional enable drops
    for (int k = 0; k < 14; k++) begin
      p = $urandom_range(40, 2);
      h = $urandom_range(p - 1, 1);
      run_wave(p, h, $urandom_range(120, 30));
      if ($urandom_range(3, 0) == 0) begin
        enable = 1'b0;
        set_sig(sig_in, $urandom_range(4, 1));
        enable = 1'b1;
      end
    end
    run_wave(6, 4, 36);
    check("final_period", 32'(period), 6);
    check("final_high", 32'(high_time), 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
